// File: rtl/opb_register_ppc2simulink_strobe.sv
// OPB slave software register, PPC -> fabric direction.
// The PowerPC writes a 32-bit word that user logic sees on user_data_out.
// Each committed write raises user_data_valid for one cycle.
// A read-only status word at offset 1 reports a 16-bit write counter.
//
// Bit numbering: OPB buses are big-endian, with bit 0 as the MSB.
// They are declared here as descending vectors, so OPB bit k is vector bit W-1-k.
// The physical wiring is unchanged:
//   - OPB_ABus[29] (word offset) is OPB_ABus[2] here.
//   - OPB_BE[0] (byte lane DBus[0:7]) is OPB_BE[3] here.
//
// Bus handshake: a transfer starts when OPB_select is high with an address
// inside the window. Sl_xferAck is high for exactly one cycle, the cycle after
// the request. Sl_DBus carries read data only in that cycle and is zero
// otherwise, because the bus is an OR-bus. The slave then waits for
// OPB_select to drop before it accepts another request. This guarantees a
// single ack per select.
module opb_register_ppc2simulink_strobe #(
  parameter logic [31:0] C_BASEADDR   = 32'h01008600,
  parameter logic [31:0] C_HIGHADDR   = 32'h010086FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_INIT       = 32'h00000000,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [C_OPB_AWIDTH-1:0] OPB_ABus,
  input  logic [3:0]              OPB_BE,
  input  logic [C_OPB_DWIDTH-1:0] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [C_OPB_DWIDTH-1:0] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [31:0]             user_data_out,
  output logic                    user_data_valid
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rst_sync_q;
  logic        rst_n;
  logic        hit;
  logic        off_q, rnw_q;
  logic [3:0]  be_q;
  logic [31:0] dbus_q;
  logic [31:0] data_q, data_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic        valid_q;
  logic        wr_commit;
  logic        unused_ok;

  // Sequential-access hint and the family string do not affect behaviour.
  assign unused_ok = OPB_seqAddr ^ (C_FAMILY != "");

  // Reset asserts at once and releases on a clock edge.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign hit = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);

  // State register for the transfer FSM.
  always_ff @(posedge OPB_Clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: HOLD is always visited, so a long select never gets a second ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hit) state_d = S_ACK;
      S_ACK:   state_d = S_HOLD;
      S_HOLD:  if (!OPB_select) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the request when it is accepted; it is used during ACK.
  always_ff @(posedge OPB_Clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q  <= 1'b0;
      rnw_q  <= 1'b1;
      be_q   <= 4'b0000;
      dbus_q <= 32'h0;
    end else if (state_q == S_IDLE && hit) begin
      off_q  <= OPB_ABus[2];
      rnw_q  <= OPB_RNW;
      be_q   <= OPB_BE;
      dbus_q <= OPB_DBus;
    end
  end

  assign wr_commit = (state_q == S_ACK) && !rnw_q && !off_q;

  // Byte-merge write data and bump the delivery counter (wraps naturally).
  always_comb begin
    data_d     = data_q;
    wr_count_d = wr_count_q;
    if (wr_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) data_d[8*i +: 8] = dbus_q[8*i +: 8];
      end
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  // Data register, counter and strobe all update on the ACK edge together.
  always_ff @(posedge OPB_Clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= C_INIT;
      wr_count_q <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      data_q     <= data_d;
      wr_count_q <= wr_count_d;
      valid_q    <= wr_commit;
    end
  end

  assign Sl_xferAck      = (state_q == S_ACK);
  assign Sl_DBus         = (Sl_xferAck && rnw_q) ? (off_q ? {16'h0000, wr_count_q} : data_q) : '0;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = data_q;
  assign user_data_valid = valid_q;

endmodule

// File: tb/tb_opb_register_ppc2simulink_strobe.sv
// Bench for the PPC -> fabric OPB software register.
module tb_opb_register_ppc2simulink_strobe;

  localparam logic [31:0] BASE = 32'h01008600;
  localparam logic [31:0] HIGH = 32'h010086FF;
  localparam logic [31:0] INIT = 32'h00000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] abus, dbus, sl_dbus, udo;
  logic [3:0]  be;
  logic        rnw, sel, seqaddr, ack, err_ack, retry, tout_sup, valid;

  opb_register_ppc2simulink_strobe dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
    .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqaddr),
    .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(err_ack), .Sl_retry(retry),
    .Sl_toutSup(tout_sup), .user_data_out(udo), .user_data_valid(valid)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_acks   = 0;
  int n_valid_seen = 0;
  int n_valid_exp  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_data;
  logic [15:0] m_cnt;
  logic [31:0] prev_udo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference write: lane i is OPB byte i, i.e. bits [31-8i -: 8]; BE[0] is be[3].
  task automatic model_write(input logic [3:0] be_v, input logic [31:0] d);
    logic [7:0] lanes[4];
    for (int i = 0; i < 4; i++) lanes[i] = m_data[31-8*i -: 8];
    for (int i = 0; i < 4; i++) if (be_v[3-i]) lanes[i] = d[31-8*i -: 8];
    m_data = {lanes[0], lanes[1], lanes[2], lanes[3]};
    m_cnt  = m_cnt + 16'd1;
    exp_q.push_back(m_data);
    n_valid_exp++;
  endtask

  // Strobe monitor: each pulse must carry the next expected word; no silent changes.
  always @(negedge clk) begin
    if (ack) n_acks++;
    if (rst_n) begin
      if (valid) begin
        n_valid_seen++;
        if (exp_q.size() == 0) check("valid_unexpected", 32'd1, 32'd0);
        else                   check("udo_at_valid", udo, exp_q.pop_front());
      end else if (udo !== prev_udo) begin
        check("udo_changed_without_valid", udo, prev_udo);
      end
    end
    prev_udo = udo;
  end

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    sel = 1'b0; rnw = 1'b1; abus = 32'h0; be = 4'h0; dbus = 32'h0;
  endtask

  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [3:0] be_v,
                      input logic [31:0] d, input int hold,
                      output logic [31:0] rd, output bit acked);
    int lat;
    @(posedge clk); #1;
    sel = 1'b1; abus = addr; rnw = !wr; be = be_v; dbus = d;
    acked = 1'b0; rd = 32'h0; lat = 0;
    while (!acked && lat < 16) begin
      @(negedge clk);
      if (ack) begin
        acked = 1'b1;
        rd = sl_dbus;
      end else begin
        lat++;
      end
    end
    if (!acked) check("ack_timeout", 32'd0, 32'd1);
    else begin
      check("ack_latency", lat, 1);
      if (wr && !addr[2]) model_write(be_v, d);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_no_ack", {31'd0, ack}, 32'd0);
      check("hold_dbus_zero", sl_dbus, 32'd0);
    end
    @(posedge clk); #1;
    bus_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    bit          acked;
    int          acks0, valid0;
    logic [31:0] addr;
    bit          wr;

    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          acked;
    int          acks0, valid0;
    logic [31:0] addr;
    bit          wr;

    bus_idle();
    seqaddr = 1'b0;
    m_data = INIT;
    m_cnt = 16'h0;
    prev_udo = INIT;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dbus", sl_dbus, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_udo", udo, INIT);
    check("const_outs", {29'd0, err_ack, retry, tout_sup}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Full-word write: strobe and data two cycles after the request.
    xfer(BASE, 1'b1, 4'b1111, 32'hDEADBEEF, 0, rd, acked);
    check("t2_valid", {31'd0, valid}, 32'd1);
    check("t2_udo", udo, 32'hDEADBEEF);

    // Partial write over it (lanes 1 and 3), then status shows two writes.
    xfer(BASE, 1'b1, 4'b0101, 32'h11223344, 0, rd, acked);
    check("t3_udo", udo, 32'hDE22BE44);
    xfer(BASE + 32'd4, 1'b0, 4'hF, 32'h0, 0, rd, acked);
    check("t3_status", rd, 32'h00000002);
    xfer(BASE, 1'b0, 4'hF, 32'h0, 0, rd, acked);
    check("t3_data_rd", rd, 32'hDE22BE44);

    // Select held for 3 extra cycles: a single ack.
    acks0 = n_acks;
    xfer(BASE, 1'b0, 4'hF, 32'h0, 3, rd, acked);
    check("t4_rd", rd, 32'hDE22BE44);
    check("t4_ack_count", n_acks - acks0, 1);

    // Reset asserted mid-ACK of a write: ack drops now, write lost, state cleared.
    @(posedge clk); #1;
    sel = 1'b1; abus = BASE; rnw = 1'b0; be = 4'hF; dbus = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    check("t1_ack_before_rst", {31'd0, ack}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t1_ack_at_rst", {31'd0, ack}, 32'd0);
    check("t1_dbus_at_rst", sl_dbus, 32'd0);
    bus_idle();
    @(negedge clk);
    check("t1_udo", udo, INIT);
    check("t1_valid", {31'd0, valid}, 32'd0);
    m_data = INIT;
    m_cnt = 16'h0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    xfer(BASE + 32'd4, 1'b0, 4'hF, 32'h0, 0, rd, acked);
    check("t1_status", rd, 32'h00000000);
    repeat (2) @(posedge clk);
    check("t1_no_valid", {31'd0, valid}, 32'd0);

    // Counter wrap: preload near the top, then step across 0xFFFF.
    @(negedge clk);
    force dut.wr_count_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.wr_count_q;
    m_cnt = 16'hFFFE;
    xfer(BASE, 1'b1, 4'hF, 32'h0BADF00D, 0, rd, acked);
    xfer(BASE + 32'd4, 1'b0, 4'hF, 32'h0, 0, rd, acked);
    check("t5_status_ffff", rd, 32'h0000FFFF);
    xfer(BASE, 1'b1, 4'b1000, 32'hA5000000, 0, rd, acked);
    xfer(BASE + 32'd4, 1'b0, 4'hF, 32'h0, 0, rd, acked);
    check("t5_status_wrap", rd, 32'h00000000);

    // Out-of-window selects: never acked.
    acks0 = n_acks;
    @(posedge clk); #1;
    sel = 1'b1; abus = HIGH + 32'd4; rnw = 1'b0; be = 4'hF; dbus = 32'h12345678;
    repeat (20) @(negedge clk);
    abus = BASE - 32'd4; rnw = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_no_ack", n_acks - acks0, 0);
    @(posedge clk); #1;
    bus_idle();

    // Write to the status offset: acked, no strobe, no change.
    valid0 = n_valid_seen;
    xfer(BASE + 32'd4, 1'b1, 4'hF, 32'hFFFFFFFF, 0, rd, acked);
    check("t6_status_acked", {31'd0, acked}, 32'd1);
    repeat (3) @(posedge clk);
    check("t6_no_valid", n_valid_seen - valid0, 0);
    xfer(BASE, 1'b0, 4'hF, 32'h0, 0, rd, acked);
    check("t6_data_kept", rd, m_data);

    // Random traffic against the model.
    for (int t = 0; t < 300; t++) begin
      addr = BASE + {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      wr   = bit'($urandom_range(0, 1));
      xfer(addr, wr, 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 2), rd, acked);
      if (!wr) check("rand_rd", rd, addr[2] ? {16'h0, m_cnt} : m_data);
    end

    repeat (4) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("valid_count", n_valid_seen, n_valid_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
